// File: rtl/aes_host_ctrl.sv
// Host-side sequencer owning the AES core control pins: accepts one request,
// runs optional key expansion and the cipher, returns the result with a timeout.
module aes_host_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          CACHE_KEY      = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [127:0] req_key,
    input  logic [127:0] req_text,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_text,
    output logic         rsp_err,
    output logic         busy,
    output logic         core_mode,
    output logic         core_ld,
    output logic         core_kld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic [127:0] core_text_out,
    input  logic         core_done,
    input  logic         core_kdone
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KWAIT,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     cache_key;
    logic             cache_vld;
    logic             key_hit;

    // A decrypt may skip expansion only when the inverse core already holds this key.
    assign key_hit = CACHE_KEY && cache_vld && (req_key == cache_key);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cache_key    <= '0;
            cache_vld    <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_text     <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            core_mode    <= 1'b0;
            core_ld      <= 1'b0;
            core_kld     <= 1'b0;
            core_key     <= '0;
            core_text_in <= '0;
        end else begin
            core_ld  <= 1'b0;
            core_kld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        core_mode    <= req_mode;
                        core_key     <= req_key;
                        core_text_in <= req_text;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (req_mode && !key_hit) begin
                            state    <= S_KLOAD;
                            core_kld <= 1'b1;
                        end else begin
                            state   <= S_LOAD;
                            core_ld <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_KLOAD: begin
                    state <= S_KWAIT;
                    cnt   <= '0;
                end
                S_KWAIT: begin
                    if (core_kdone) begin
                        cache_key <= core_key;
                        cache_vld <= 1'b1;
                        state     <= S_LOAD;
                        core_ld   <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        rsp_text  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        cache_vld <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
                S_RUN: begin
                    // A done sampled on the terminal count still counts as success.
                    if (core_done) begin
                        rsp_text  <= core_text_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_text  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        cache_vld <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed bench for aes_host_ctrl: table of full transactions against a simple
// latency-programmable core model, plus backpressure and reset-abort sequences.
module tb_aes_host_ctrl;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic         req_valid;
    logic         req_mode;
    logic [127:0] req_key;
    logic [127:0] req_text;
    logic         rsp_ready;
    logic [127:0] core_text_out;
    logic         core_done;
    logic         core_kdone;

    logic         a_req_ready, a_rsp_valid, a_rsp_err, a_busy, a_core_mode, a_core_ld, a_core_kld;
    logic [127:0] a_rsp_text, a_core_key, a_core_text_in;
    logic         b_req_ready, b_rsp_valid, b_rsp_err, b_busy, b_core_mode, b_core_ld, b_core_kld;
    logic [127:0] b_rsp_text, b_core_key, b_core_text_in;

    always #5 clk = ~clk;

    aes_host_ctrl #(.TIMEOUT_CYCLES(64), .CACHE_KEY(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_text(a_rsp_text), .rsp_err(a_rsp_err),
        .busy(a_busy), .core_mode(a_core_mode), .core_ld(a_core_ld), .core_kld(a_core_kld),
        .core_key(a_core_key), .core_text_in(a_core_text_in), .core_text_out(core_text_out),
        .core_done(core_done), .core_kdone(core_kdone)
    );

    aes_host_ctrl #(.TIMEOUT_CYCLES(64), .CACHE_KEY(1'b0)) u_dut_nc (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_text(b_rsp_text), .rsp_err(b_rsp_err),
        .busy(b_busy), .core_mode(b_core_mode), .core_ld(b_core_ld), .core_kld(b_core_kld),
        .core_key(b_core_key), .core_text_in(b_core_text_in), .core_text_out(core_text_out),
        .core_done(core_done), .core_kdone(core_kdone)
    );

    wire         m_req_ready    = sel ? b_req_ready    : a_req_ready;
    wire         m_rsp_valid    = sel ? b_rsp_valid    : a_rsp_valid;
    wire         m_rsp_err      = sel ? b_rsp_err      : a_rsp_err;
    wire         m_busy         = sel ? b_busy         : a_busy;
    wire         m_core_mode    = sel ? b_core_mode    : a_core_mode;
    wire         m_core_ld      = sel ? b_core_ld      : a_core_ld;
    wire         m_core_kld     = sel ? b_core_kld     : a_core_kld;
    wire [127:0] m_rsp_text     = sel ? b_rsp_text     : a_rsp_text;
    wire [127:0] m_core_key     = sel ? b_core_key     : a_core_key;
    wire [127:0] m_core_text_in = sel ? b_core_text_in : a_core_text_in;

    // Core model: known vector pairs, done lat_cfg cycles after ld (0 = never), kdone 5 after kld.
    int unsigned  lat_cfg = 12;
    int unsigned  cd = 0;
    int unsigned  kcd = 0;
    logic [127:0] res = '0;
    int           cyc = 0;
    int           ld_cnt = 0;
    int           kld_cnt = 0;
    int           ld_cyc = 0;

    function automatic logic [127:0] core_fn(input logic mode, input logic [127:0] key,
                                             input logic [127:0] text);
        if (!mode && key == K1 && text == PT1) return CT1;
        if ( mode && key == K1 && text == CT1) return PT1;
        if (!mode && key == K2 && text == PT2) return CT2;
        if ( mode && key == K2 && text == CT2) return PT2;
        return ~text;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_core_ld) begin
            cd     <= lat_cfg;
            res    <= core_fn(m_core_mode, m_core_key, m_core_text_in);
            ld_cnt <= ld_cnt + 1;
            ld_cyc <= cyc;
        end else if (cd != 0) begin
            cd <= cd - 1;
        end
        if (m_core_kld) begin
            kcd     <= 5;
            kld_cnt <= kld_cnt + 1;
        end else if (kcd != 0) begin
            kcd <= kcd - 1;
        end
    end

    assign core_done     = (cd == 1);
    assign core_kdone    = (kcd == 1);
    assign core_text_out = res;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         sel;
        logic         mode;
        logic [127:0] key;
        logic [127:0] text;
        int unsigned  lat;
        logic [127:0] exp_text;
        logic         exp_err;
        int           exp_kld;
        int           exp_gap;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic m, input logic [127:0] k,
                                input logic [127:0] t, input int unsigned l,
                                input logic [127:0] et, input logic ee, input int ek, input int eg);
        vec_t v;
        v.sel = s; v.mode = m; v.key = k; v.text = t; v.lat = l;
        v.exp_text = et; v.exp_err = ee; v.exp_kld = ek; v.exp_gap = eg;
        return v;
    endfunction

    int k0, l0;

    // Present a request and wait for its accept; checks the load pulse that follows.
    task automatic issue(input vec_t v);
        int i;
        sel = v.sel; lat_cfg = v.lat;
        k0 = kld_cnt; l0 = ld_cnt;
        req_mode = v.mode; req_key = v.key; req_text = v.text; req_valid = 1'b1;
        for (i = 0; i < 50 && !m_req_ready; i++) @(negedge clk);
        check("accept_ready", 128'(m_req_ready), 128'(1));
        @(negedge clk);
        req_valid = 1'b0;
        if (v.exp_kld != 0) check("kld_after_accept", 128'(m_core_kld), 128'(1));
        else                check("ld_after_accept", 128'(m_core_ld), 128'(1));
        check("busy_after_accept", 128'(m_busy), 128'(1));
    endtask

    task automatic collect(input vec_t v);
        for (int i = 0; i < 300; i++) begin
            if (m_rsp_valid) break;
            @(negedge clk);
        end
        check("rsp_valid_seen", 128'(m_rsp_valid), 128'(1));
        check("rsp_text", m_rsp_text, v.exp_text);
        check("rsp_err", 128'(m_rsp_err), 128'(v.exp_err));
        check("ld_to_rsp_cycles", 128'(cyc - ld_cyc), 128'(v.exp_gap));
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 128'(m_rsp_valid), 128'(0));
        check("req_ready_after_hs", 128'(m_req_ready), 128'(1));
        check("busy_after_hs", 128'(m_busy), 128'(0));
    endtask

    task automatic run_vec(input vec_t v);
        issue(v);
        collect(v);
        check("kld_count", 128'(kld_cnt - k0), 128'(v.exp_kld));
        check("ld_count", 128'(ld_cnt - l0), 128'(1));
        handshake();
    endtask

    function automatic logic [9:0] out_vec();
        return {m_req_ready, m_rsp_valid, m_rsp_err, m_busy, m_core_mode, m_core_ld, m_core_kld,
                |m_rsp_text, |m_core_key, |m_core_text_in};
    endfunction

    vec_t vecs[11];
    vec_t v;
    logic seen_rsp;
    int   lh;

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_mode = 1'b0;
        req_key = '0; req_text = '0; rsp_ready = 1'b0;

        vecs[0]  = mk(0, 0, K1, PT1, 12, CT1, 0, 0, 13);
        vecs[1]  = mk(0, 1, K1, CT1, 12, PT1, 0, 1, 13);
        vecs[2]  = mk(0, 1, K1, CT1, 12, PT1, 0, 0, 13);
        vecs[3]  = mk(0, 1, K2, CT2, 12, PT2, 0, 1, 13);
        vecs[4]  = mk(0, 0, K1, PT1, 12, CT1, 0, 0, 13);
        vecs[5]  = mk(0, 1, K2, CT2, 12, PT2, 0, 0, 13);
        vecs[6]  = mk(1, 1, K1, CT1, 12, PT1, 0, 1, 13);
        vecs[7]  = mk(1, 1, K1, CT1, 12, PT1, 0, 1, 13);
        vecs[8]  = mk(0, 0, K1, PT1, 0, 128'h0, 1, 0, 65);
        vecs[9]  = mk(0, 1, K2, CT2, 12, PT2, 0, 1, 13);
        vecs[10] = mk(0, 0, K1, PT1, 64, CT1, 0, 0, 65);

        repeat (3) @(negedge clk);
        check("reset_outputs", 128'(out_vec()), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 128'(m_req_ready), 128'(1));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Held-off response with a competing request pending.
        issue(vecs[0]);
        collect(vecs[0]);
        req_mode = 1'b0; req_key = K2; req_text = PT2; req_valid = 1'b1;
        lh = ld_cnt;
        repeat (10) begin
            @(negedge clk);
            check("hold_rsp_valid", 128'(m_rsp_valid), 128'(1));
            check("hold_rsp_text", m_rsp_text, CT1);
            check("hold_rsp_err", 128'(m_rsp_err), 128'(0));
            check("hold_req_ready", 128'(m_req_ready), 128'(0));
        end
        check("hold_no_ld", 128'(ld_cnt - lh), 128'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_rsp_valid_drop", 128'(m_rsp_valid), 128'(0));
        check("hs_plus1_req_ready", 128'(m_req_ready), 128'(1));
        @(negedge clk);
        req_valid = 1'b0;
        check("hs_plus2_ld", 128'(m_core_ld), 128'(1));
        v = mk(0, 0, K2, PT2, 12, CT2, 0, 0, 13);
        collect(v);
        handshake();

        // Reset in the middle of RUN; the stray done after release must be ignored.
        issue(vecs[0]);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_outputs", 128'(out_vec()), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_midrun_reset", 128'(m_req_ready), 128'(1));
        seen_rsp = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_rsp_valid || m_busy) seen_rsp = 1'b1;
        end
        check("stray_done_ignored", 128'(seen_rsp), 128'(0));
        run_vec(mk(0, 1, K1, CT1, 12, PT1, 0, 1, 13));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
